// File: rtl/flow_led_ctrl_if.sv
// flow_led_ctrl_if: control/status bundle between board-level control and the LED engine.
//   master modport (control side): drives en, mode, div_load, div_val (and duty when
//                                   FLOW_LED_PWM_EN is defined); observes led, step, wrap.
//   slave modport  (LED engine)  : the mirror image.
//   LED_W/DIV_W must match the parameters of the flow_led_ctrl instance it is bound to.
interface flow_led_ctrl_if #(
    parameter int unsigned LED_W = 4,
    parameter int unsigned DIV_W = 24
);
    logic             en;
    logic [1:0]       mode;
    logic             div_load;
    logic [DIV_W-1:0] div_val;
`ifdef FLOW_LED_PWM_EN
    logic [3:0]       duty;
`endif
    logic [LED_W-1:0] led;
    logic             step;
    logic             wrap;

`ifdef FLOW_LED_PWM_EN
    modport master (output en, mode, div_load, div_val, duty, input led, step, wrap);
    modport slave  (input en, mode, div_load, div_val, duty, output led, step, wrap);
`else
    modport master (output en, mode, div_load, div_val, input led, step, wrap);
    modport slave  (input en, mode, div_load, div_val, output led, step, wrap);
`endif
endinterface

// File: rtl/flow_led_ctrl.sv
// flow_led_ctrl: parametrised LED pattern engine.
//   A programmable prescaler divides sys_clk50m into a step tick; each tick advances an
//   LED_W-wide pattern in rotate-left, rotate-right, bounce or blink-all mode.
// Ports:
//   sys_clk50m  in   system clock, rising edge
//   rst         in   synchronous active-high reset
//   bus         slave modport of flow_led_ctrl_if:
//                 en, mode[1:0], div_load, div_val[DIV_W-1:0] (in)
//                 led[LED_W-1:0], step, wrap                  (out, all registered)
// Configuration:
//   FLOW_LED_PWM_EN  when defined, adds bus.duty[3:0] and a free-running 4-bit PWM counter
//                    that gates led; pattern, step and wrap are unaffected.
module flow_led_ctrl #(
    parameter int unsigned LED_W       = 4,
    parameter int unsigned DIV_W       = 24,
    parameter int unsigned DIV_DEFAULT = 4
) (
    input  logic           sys_clk50m,
    input  logic           rst,
    flow_led_ctrl_if.slave bus
);

    typedef enum logic {DirLeft, DirRight} dir_e;

    localparam logic [LED_W-1:0] LsbOnly   = LED_W'(1);
    localparam logic [LED_W-1:0] MsbOnly   = LsbOnly << (LED_W - 1);
    localparam logic [LED_W-1:0] AllOnes   = '1;
    localparam logic [DIV_W-1:0] PeriodRst = DIV_W'(DIV_DEFAULT);

    logic [LED_W-1:0] pat_q, pat_d;
    logic [DIV_W-1:0] cnt_q, period_q;
    dir_e             dir_q, dir_d;
    logic             step_q, wrap_q, wrap_d;
    logic             tick;

    // A period load in the same cycle wins over the tick.
    assign tick = bus.en & ~bus.div_load & (cnt_q == period_q - DIV_W'(1));

    always_comb begin
        pat_d  = pat_q;
        dir_d  = dir_q;
        wrap_d = 1'b0;
        if (tick) begin
            if (bus.mode == 2'b11) begin
                // Blink: anything other than all-zero/all-one recovers to dark, no wrap.
                if (pat_q == '0) begin
                    pat_d = AllOnes;
                end else if (pat_q == AllOnes) begin
                    pat_d  = '0;
                    wrap_d = 1'b1;
                end else begin
                    pat_d = '0;
                end
            end else if (!$onehot(pat_q)) begin
                // Recovery/seed for the one-hot modes; never a wrap.
                pat_d = LsbOnly;
                dir_d = DirLeft;
            end else begin
                case (bus.mode)
                    2'b00: begin
                        pat_d  = {pat_q[LED_W-2:0], pat_q[LED_W-1]};
                        wrap_d = (pat_q == MsbOnly);
                    end
                    2'b01: begin
                        pat_d  = {pat_q[0], pat_q[LED_W-1:1]};
                        wrap_d = (pat_q == LsbOnly);
                    end
                    default: begin
                        // Bounce: ends reverse direction; dir is only touched here.
                        if (pat_q == MsbOnly) begin
                            dir_d = DirRight;
                            pat_d = pat_q >> 1;
                        end else if (pat_q == LsbOnly && dir_q == DirRight) begin
                            dir_d = DirLeft;
                            pat_d = pat_q << 1;
                        end else if (dir_q == DirLeft) begin
                            pat_d = pat_q << 1;
                        end else begin
                            pat_d = pat_q >> 1;
                        end
                        wrap_d = (pat_d == LsbOnly);
                    end
                endcase
            end
        end
    end

    always_ff @(posedge sys_clk50m) begin
        if (rst) begin
            pat_q    <= '0;
            cnt_q    <= '0;
            period_q <= PeriodRst;
            dir_q    <= DirLeft;
            step_q   <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            if (bus.div_load) begin
                period_q <= (bus.div_val == '0) ? DIV_W'(1) : bus.div_val;
                cnt_q    <= '0;
            end else if (bus.en) begin
                cnt_q <= tick ? '0 : cnt_q + DIV_W'(1);
            end
            pat_q  <= pat_d;
            dir_q  <= dir_d;
            step_q <= tick;
            wrap_q <= wrap_d;
        end
    end

    assign bus.step = step_q;
    assign bus.wrap = wrap_q;

`ifdef FLOW_LED_PWM_EN
    logic [3:0]       pwm_cnt_q;
    logic [LED_W-1:0] led_q;

    // led tracks the next pattern so it updates on the same edge as pat.
    always_ff @(posedge sys_clk50m) begin
        if (rst) begin
            pwm_cnt_q <= 4'd0;
            led_q     <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + 4'd1;
            led_q     <= pat_d & {LED_W{pwm_cnt_q < bus.duty}};
        end
    end

    assign bus.led = led_q;
`else
    assign bus.led = pat_q;
`endif

endmodule

// File: tb/tb_flow_led_ctrl.sv
// tb_flow_led_ctrl: directed bench for flow_led_ctrl (LED_W=4, DIV_DEFAULT=4).
//   A position-based reference model is compared against led/step/wrap every cycle, and
//   hand-computed literal expectations pin the model at the key points of each scenario.
module tb_flow_led_ctrl;

    localparam int W = 4;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    flow_led_ctrl_if #(.LED_W(W), .DIV_W(24)) bus ();

    flow_led_ctrl #(
        .LED_W      (W),
        .DIV_W      (24),
        .DIV_DEFAULT(4)
    ) dut (
        .sys_clk50m(clk),
        .rst       (rst),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // With PWM gating, led may only show a subset of the pattern.
    task automatic chk_led(input string name, input logic [W-1:0] exp);
`ifdef FLOW_LED_PWM_EN
        chk({name, "_subset"}, 32'(bus.led & ~exp), 32'd0);
`else
        chk(name, 32'(bus.led), 32'(exp));
`endif
    endtask

    // Reference model: pattern held as a position (0..W-1), -1 = all dark, -2 = all lit.
    int         m_cnt, m_period, m_pos, m_pwm;
    bit         m_dir_right, m_step, m_wrap, m_valid, m_tick, m_gate;
    logic [W-1:0] m_led;

    function automatic logic [W-1:0] shape(input int pos);
        logic [W-1:0] v;
        v = '0;
        if (pos == -2) v = '1;
        else if (pos >= 0) v[pos] = 1'b1;
        return v;
    endfunction

    initial m_valid = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_cnt       = 0;
            m_period    = 4;
            m_pos       = -1;
            m_dir_right = 1'b0;
            m_step      = 1'b0;
            m_wrap      = 1'b0;
            m_pwm       = 0;
            m_led       = '0;
            m_valid     = 1'b1;
        end else begin
            m_tick = bus.en && !bus.div_load && (m_cnt == m_period - 1);
            if (bus.div_load) begin
                m_period = (bus.div_val == 0) ? 1 : int'(bus.div_val);
                m_cnt    = 0;
            end else if (bus.en) begin
                m_cnt = m_tick ? 0 : m_cnt + 1;
            end
            m_step = m_tick;
            m_wrap = 1'b0;
            if (m_tick) begin
                if (bus.mode == 2'd3) begin
                    if (m_pos >= 0) m_pos = -1;
                    else if (m_pos == -1) m_pos = -2;
                    else begin
                        m_pos  = -1;
                        m_wrap = 1'b1;
                    end
                end else if (m_pos < 0) begin
                    m_pos       = 0;
                    m_dir_right = 1'b0;
                end else if (bus.mode == 2'd0) begin
                    m_wrap = (m_pos == W - 1);
                    m_pos  = (m_pos + 1) % W;
                end else if (bus.mode == 2'd1) begin
                    m_wrap = (m_pos == 0);
                    m_pos  = (m_pos + W - 1) % W;
                end else begin
                    if (m_pos == W - 1) begin
                        m_dir_right = 1'b1;
                        m_pos       = W - 2;
                    end else if (m_pos == 0 && m_dir_right) begin
                        m_dir_right = 1'b0;
                        m_pos       = 1;
                    end else begin
                        m_pos = m_dir_right ? m_pos - 1 : m_pos + 1;
                    end
                    m_wrap = (m_pos == 0);
                end
            end
`ifdef FLOW_LED_PWM_EN
            m_gate = (m_pwm < int'(bus.duty));
            m_pwm  = (m_pwm + 1) % 16;
`else
            m_gate = 1'b1;
`endif
            m_led = m_gate ? shape(m_pos) : '0;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_led", 32'(bus.led), 32'(m_led));
            chk("model_step", 32'(bus.step), 32'(m_step));
            chk("model_wrap", 32'(bus.wrap), 32'(m_wrap));
        end
    end

    logic [W-1:0] t1 [5];
    logic [W-1:0] t2 [7];

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        t1           = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        t2           = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
        rst          = 1'b1;
        bus.en       = 1'b0;
        bus.mode     = 2'd0;
        bus.div_load = 1'b0;
        bus.div_val  = '0;
`ifdef FLOW_LED_PWM_EN
        bus.duty     = 4'd15;
`endif
        @(negedge clk);
        chk("reset_led", 32'(bus.led), 32'd0);
        chk("reset_step", 32'(bus.step), 32'd0);
        chk("reset_wrap", 32'(bus.wrap), 32'd0);

        // 1: default period 4, rotate-left from reset
        rst    = 1'b0;
        bus.en = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k % 4 == 0) begin
                chk_led("t1_led", t1[k/4-1]);
                chk("t1_step", 32'(bus.step), 32'd1);
                chk("t1_wrap", 32'(bus.wrap), (k == 20) ? 32'd1 : 32'd0);
            end else begin
                chk("t1_nostep", 32'(bus.step), 32'd0);
            end
        end

        // 2: period 1, bounce
        bus.div_load = 1'b1;
        bus.div_val  = 24'd1;
        bus.mode     = 2'd2;
        @(negedge clk);
        bus.div_load = 1'b0;
        chk("t2_load_step", 32'(bus.step), 32'd0);
        chk_led("t2_load_led", 4'b0001);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            chk_led("t2_led", t2[i]);
            chk("t2_step", 32'(bus.step), 32'd1);
            chk("t2_wrap", 32'(bus.wrap), (i == 5) ? 32'd1 : 32'd0);
        end

        // 3: load of 0 acts as 1 and suppresses the coincident tick; then period 3
        bus.div_load = 1'b1;
        bus.div_val  = 24'd0;
        @(negedge clk);
        bus.div_load = 1'b0;
        chk("t3_load0_nostep", 32'(bus.step), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3_div1_step", 32'(bus.step), 32'd1);
        end
        bus.div_load = 1'b1;
        bus.div_val  = 24'd3;
        @(negedge clk);
        bus.div_load = 1'b0;
        chk("t3_load3_nostep", 32'(bus.step), 32'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("t3_div3_step", 32'(bus.step), (i % 3 == 2) ? 32'd1 : 32'd0);
        end

        // 4: freeze at cnt=2, then one more clock to the step
        bus.en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t4_frozen_step", 32'(bus.step), 32'd0);
        end
        bus.en = 1'b1;
        @(negedge clk);
        chk("t4_resume_step", 32'(bus.step), 32'd1);

        // 5: from 0100 switch to blink
        rst = 1'b1;
        @(negedge clk);
        rst          = 1'b0;
        bus.div_load = 1'b1;
        bus.div_val  = 24'd1;
        bus.mode     = 2'd0;
        @(negedge clk);
        bus.div_load = 1'b0;
        chk_led("t5_load_led", 4'b0000);
        @(negedge clk);
        chk_led("t5_seed_led", 4'b0001);
        chk("t5_seed_wrap", 32'(bus.wrap), 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk_led("t5_pre_led", 4'b0100);
        bus.mode = 2'd3;
        @(negedge clk);
        chk_led("t5_recover_led", 4'b0000);
        chk("t5_recover_step", 32'(bus.step), 32'd1);
        chk("t5_recover_wrap", 32'(bus.wrap), 32'd0);
        @(negedge clk);
        chk_led("t5_on_led", 4'b1111);
        chk("t5_on_wrap", 32'(bus.wrap), 32'd0);
        @(negedge clk);
        chk_led("t5_off_led", 4'b0000);
        chk("t5_off_wrap", 32'(bus.wrap), 32'd1);

        // 6: reset mid-period restores the default period
        rst = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        bus.mode = 2'd0;
        repeat (16) @(negedge clk);
        chk_led("t6_pre_led", 4'b1000);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6_rst_led", 32'(bus.led), 32'd0);
        chk("t6_rst_step", 32'(bus.step), 32'd0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk("t6_period_step", 32'(bus.step), (k == 4) ? 32'd1 : 32'd0);
        end
        chk_led("t6_first_led", 4'b0001);

`ifdef FLOW_LED_PWM_EN
        begin
            int lit;
            bus.duty = 4'd4;
            lit      = 0;
            for (int i = 0; i < 16; i++) begin
                @(negedge clk);
                if (bus.led != '0) lit++;
            end
            chk("pwm_duty4_on", 32'(lit), 32'd4);
            bus.duty = 4'd0;
            lit      = 0;
            for (int i = 0; i < 16; i++) begin
                @(negedge clk);
                if (bus.led != '0) lit++;
            end
            chk("pwm_duty0_on", 32'(lit), 32'd0);
        end
`endif

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
